maxpool1d_frame: RTL
====================

Name: maxpool1d_frame

Overview:
- Downstream stage of the conv2d layer in the keyword-spotting CNN datapath.
- Captures one full conv2d output frame, which arrives as a single-cycle `data_valid` pulse with no backpressure.
- Performs non-overlapping max pooling along the width axis, one filter channel per cycle.
- Emits the pooled frame as one wide vector with a one-cycle valid pulse; this feeds the next conv/dense stage.

Parameters:
- INPUT_WIDTH, 32, columns per input frame (matches conv2d INPUT_WIDTH)
- INPUT_HEIGHT, 1, rows per frame; pooling never crosses rows
- NUM_FILTERS, 32, channels per position (conv2d NUM_FILTERS)
- POOL_SIZE, 2, window length along width; stride equals POOL_SIZE; must be >= 1
- ACTIV_BITS, 8, unsigned activation width
- OUT_WIDTH, INPUT_WIDTH/POOL_SIZE (integer floor), derived; not overridden

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  INPUT_WIDTH*INPUT_HEIGHT*NUM_FILTERS*ACTIV_BITS  frame; element (h,w,f) at bit offset (h*INPUT_WIDTH*NUM_FILTERS + w*NUM_FILTERS + f)*ACTIV_BITS
- data_valid  in  1  frame-present strobe
- data_out  out  OUT_WIDTH*INPUT_HEIGHT*NUM_FILTERS*ACTIV_BITS  pooled frame; element (h,o,f) at (h*OUT_WIDTH*NUM_FILTERS + o*NUM_FILTERS + f)*ACTIV_BITS
- data_out_valid  out  1  one-cycle pulse; data_out is valid from this cycle until the next pulse
- busy  out  1  high in RUN and DONE
- overrun  out  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset (rst high at a rising edge):
  - state <= IDLE; filter counter <= 0.
  - frame buffer, shadow register, data_out <= 0.
  - data_out_valid, busy, overrun <= 0.
  - Reset in the middle of a frame aborts that frame; no valid pulse follows.
- FSM states:
  - IDLE: data_valid=1 → frame buffer <= data_in, f <= 0, next state RUN. Otherwise stay in IDLE.
  - RUN: each cycle, for every h and every o in [0, OUT_WIDTH), shadow(h,o,f) <= max over k in [0, POOL_SIZE) of buf(h, o*POOL_SIZE+k, f). Then f <= f+1. When f == NUM_FILTERS-1, next state DONE.
  - DONE: data_out <= shadow; data_out_valid <= 1 for exactly one cycle; next state IDLE.
- Latency: valid sampled at edge k → data_out_valid high in the cycle after edge k+NUM_FILTERS+1. With default parameters that is 33 cycles.
- Throughput: one frame per NUM_FILTERS+2 cycles.
- Arithmetic:
  - Comparison is unsigned, full ACTIV_BITS; inputs are post-ReLU.
  - Ties take the lowest-index value; the result is identical either way.
  - No width growth, no saturation.
- Boundary conditions:
  - Trailing columns w >= OUT_WIDTH*POOL_SIZE are ignored.
  - POOL_SIZE=1 gives an identity copy with the same latency.
- data_out holds its value between pulses; it never changes during RUN.
- overrun:
  - data_valid=1 while in RUN or DONE → frame dropped, buffer untouched, overrun pulses for one cycle (registered, at the next edge).
  - The in-flight frame completes unaffected.
- busy = (state != IDLE), registered; it is low in the same cycle data_out_valid is high.
- data_valid=1 in IDLE in the same cycle data_out_valid is high → accepted normally; no overrun.
- data_in is sampled only on the IDLE accept edge.

Decomposition:
- Shared package `cnn_pkg`:
  - ACTIV_BITS default.
  - FSM state typedef/encoding (IDLE=0, RUN=1, DONE=2; 2 bits).
  - Offset helper functions for frame bit offset (h,w,f).
- Sub-module `max_reduce`:
  - Purely combinational unsigned maximum of POOL_SIZE ACTIV_BITS-wide values.
  - Instantiated INPUT_HEIGHT*OUT_WIDTH times inside a generate loop, operating on the filter slice selected by f.
- FSM, counter, buffers and output register stay in the top module.

Test Plan:
- Defaults; frame with element value (w*7+f)&0xFF; pulse data_valid once → data_out_valid exactly 33 cycles later; each pooled element equals the value at w=2o+1; busy high for 33 cycles.
- INPUT_WIDTH=5, NUM_FILTERS=2, POOL_SIZE=2; filter0 columns {3,9,200,1,255}, filter1 all 0x80 → out f0={9,200}, f1={0x80,0x80}; column 4 (255) ignored; latency 3.
- Defaults; second data_valid 5 cycles after the first → overrun pulses once; one data_out_valid only; output matches the first frame.
- Assert rst 10 cycles after accept → all outputs 0 next cycle; no valid pulse; a new frame afterwards completes with correct values.
- Back-to-back: data_valid asserted in the data_out_valid cycle → accepted with no overrun; second result pulse exactly 34 cycles after the first.
- POOL_SIZE=1, small config → data_out equals data_in bit-for-bit; latency NUM_FILTERS+1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the keyword-spotting CNN datapath stages.
package cnn_pkg;

    localparam int ACTIV_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_e;

    // Bit offset of element (h,w,f) in a frame laid out row-major, width-major, filter-minor.
    function automatic int frame_off(input int h, input int w, input int f,
                                     input int width, input int nf, input int ab);
        return (h * width * nf + w * nf + f) * ab;
    endfunction

endpackage

// File: rtl/max_reduce.sv
// Combinational unsigned maximum over one pooling window.
module max_reduce
    import cnn_pkg::*;
#(
    parameter int POOL_SIZE  = 2,
    parameter int ACTIV_BITS = ACTIV_BITS_DEFAULT
) (
    input  logic [POOL_SIZE*ACTIV_BITS-1:0] vals_i,
    output logic [ACTIV_BITS-1:0]           max_o
);

    // Strict compare keeps the lowest-index value on ties.
    always_comb begin
        max_o = vals_i[ACTIV_BITS-1:0];
        for (int k = 1; k < POOL_SIZE; k++) begin
            if (vals_i[k*ACTIV_BITS +: ACTIV_BITS] > max_o)
                max_o = vals_i[k*ACTIV_BITS +: ACTIV_BITS];
        end
    end

endmodule

// File: rtl/maxpool1d_frame.sv
// Frame-level 1-D max pooling along width; one filter channel reduced per cycle.
module maxpool1d_frame
    import cnn_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int INPUT_HEIGHT = 1,
    parameter int NUM_FILTERS  = 32,
    parameter int POOL_SIZE    = 2,
    parameter int ACTIV_BITS   = ACTIV_BITS_DEFAULT
) (
    input  logic                                                               clk,
    input  logic                                                               rst,
    input  logic [INPUT_WIDTH*INPUT_HEIGHT*NUM_FILTERS*ACTIV_BITS-1:0]             data_in,
    input  logic                                                               data_valid,
    output logic [(INPUT_WIDTH/POOL_SIZE)*INPUT_HEIGHT*NUM_FILTERS*ACTIV_BITS-1:0] data_out,
    output logic                                                               data_out_valid,
    output logic                                                               busy,
    output logic                                                               overrun
);

    localparam int OUT_WIDTH = INPUT_WIDTH / POOL_SIZE;
    localparam int IN_BITS   = INPUT_WIDTH * INPUT_HEIGHT * NUM_FILTERS * ACTIV_BITS;
    localparam int OUT_BITS  = OUT_WIDTH * INPUT_HEIGHT * NUM_FILTERS * ACTIV_BITS;
    localparam int FW        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    pool_state_e           state_q;
    logic [FW-1:0]         f_q;
    logic [IN_BITS-1:0]    frame_q;
    logic [OUT_BITS-1:0]   shadow_q;
    logic [OUT_BITS-1:0]   data_out_q;
    logic                  dv_q;
    logic                  busy_q;
    logic                  ovr_q;

    logic [ACTIV_BITS-1:0] pooled [INPUT_HEIGHT][OUT_WIDTH];

    // One reducer per output position; all of them look at the current filter slice f_q.
    for (genvar h = 0; h < INPUT_HEIGHT; h++) begin : g_row
        for (genvar o = 0; o < OUT_WIDTH; o++) begin : g_col
            logic [POOL_SIZE*ACTIV_BITS-1:0] win;

            // Gather the POOL_SIZE columns of this window for filter f_q.
            always_comb begin
                win = '0;
                for (int k = 0; k < POOL_SIZE; k++) begin
                    win[k*ACTIV_BITS +: ACTIV_BITS] =
                        frame_q[frame_off(h, o*POOL_SIZE + k, int'(f_q),
                                          INPUT_WIDTH, NUM_FILTERS, ACTIV_BITS) +: ACTIV_BITS];
                end
            end

            max_reduce #(
                .POOL_SIZE (POOL_SIZE),
                .ACTIV_BITS(ACTIV_BITS)
            ) u_max (
                .vals_i(win),
                .max_o (pooled[h][o])
            );
        end
    end

    // Control FSM, filter counter, frame/shadow buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            f_q        <= '0;
            frame_q    <= '0;
            shadow_q   <= '0;
            data_out_q <= '0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            ovr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        frame_q <= data_in;
                        f_q     <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // A strobe here drops the new frame; the in-flight one carries on.
                    ovr_q <= data_valid;
                    for (int h = 0; h < INPUT_HEIGHT; h++) begin
                        for (int o = 0; o < OUT_WIDTH; o++) begin
                            shadow_q[frame_off(h, o, int'(f_q), OUT_WIDTH, NUM_FILTERS,
                                               ACTIV_BITS) +: ACTIV_BITS] <= pooled[h][o];
                        end
                    end
                    f_q <= f_q + 1'b1;
                    if (f_q == FW'(NUM_FILTERS - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    ovr_q      <= data_valid;
                    data_out_q <= shadow_q;
                    dv_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = dv_q;
    assign busy           = busy_q;
    assign overrun        = ovr_q;

endmodule
